// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: one frame per request, clocked by clknexys only.
// SCLKclk is a level input that is edge-detected here; it never clocks flops.
//
// Ports:
//   clknexys  in   system clock
//   rst       in   asynchronous active-low reset
//   SCLKclk   in   divided serial clock level, synchronous to clknexys
//   start     in   frame request, sampled only while idle
//   tx_data   in   word to transmit, latched on accepted start
//   miso      in   serial data from the peripheral
//   cs_n      out  chip select, active-low
//   sclk_out  out  gated serial clock, CPOL=0
//   mosi      out  serial data to the peripheral, MSB first
//   busy      out  high from accepted start until the end of the idle gap
//   done      out  one-cycle pulse when rx_data is updated
//   rx_data   out  last received word
//
// Build option: define MOSI_TX_EN to include the transmit shift path.
// Without it mosi is tied low and tx_data is ignored; receive timing is
// identical in both builds.

module spi_frame_master #(
    parameter int FRAME_BITS = 16,
    parameter int IDLE_GAP   = 2
) (
    input  logic                  clknexys,
    input  logic                  rst,
    input  logic                  SCLKclk,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  miso,
    output logic                  cs_n,
    output logic                  sclk_out,
    output logic                  mosi,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_data
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] C_BITS = CW'(FRAME_BITS);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [3:0] C_GAP_LAST = 4'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t                r_state;
    logic                  r_sclk_q;
    logic                  r_cs_n;
    logic                  r_sclk_out;
    logic                  r_busy;
    logic                  r_done;
    logic [FRAME_BITS-1:0] r_rx_sh;
    logic [FRAME_BITS-1:0] r_rx_data;
    logic [CW-1:0]         r_bitcnt;
    logic [3:0]            r_gap;

    logic w_rise;
    logic w_fall;

    // Rise and fall cannot decode together: both compare the same two bits.
    assign w_rise = SCLKclk & ~r_sclk_q;
    assign w_fall = ~SCLKclk & r_sclk_q;

`ifdef MOSI_TX_EN
    // The MSB of the shift register is the bit currently on the wire.
    logic [FRAME_BITS-1:0] r_tx_sh;
    assign mosi = r_tx_sh[FRAME_BITS-1];
`else
    logic w_tx_unused;
    assign w_tx_unused = ^tx_data;
    assign mosi = 1'b0;
`endif

    always_ff @(posedge clknexys or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_sclk_q   <= 1'b0;
            r_cs_n     <= 1'b1;
            r_sclk_out <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_bitcnt   <= '0;
            r_gap      <= '0;
`ifdef MOSI_TX_EN
            r_tx_sh    <= '0;
`endif
        end else begin
            r_sclk_q <= SCLKclk;
            r_done   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_cs_n     <= 1'b1;
                    r_sclk_out <= 1'b0;
                    if (start) begin
                        r_state  <= ST_SETUP;
                        r_busy   <= 1'b1;
                        r_cs_n   <= 1'b0;
                        r_bitcnt <= C_BITS;
                        r_rx_sh  <= '0;
`ifdef MOSI_TX_EN
                        r_tx_sh  <= tx_data;
`endif
                    end
                end
                ST_SETUP: begin
                    // Waiting for a fall guarantees cs_n setup of at
                    // least half an sclk period before the first rise.
                    if (w_fall) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sclk_out <= SCLKclk;
                    if (w_rise) begin
                        r_rx_sh  <= {r_rx_sh[FRAME_BITS-2:0], miso};
                        r_bitcnt <= r_bitcnt - C_ONE;
                    end
                    if (w_fall) begin
                        if (r_bitcnt != '0) begin
`ifdef MOSI_TX_EN
                            r_tx_sh <= {r_tx_sh[FRAME_BITS-2:0], 1'b0};
`endif
                        end else begin
                            r_state    <= ST_HOLD;
                            r_sclk_out <= 1'b0;
`ifdef MOSI_TX_EN
                            r_tx_sh    <= '0;
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    // One full sclk period of cs_n hold after the last bit.
                    if (w_fall) begin
                        r_state   <= ST_GAP;
                        r_cs_n    <= 1'b1;
                        r_rx_data <= r_rx_sh;
                        r_done    <= 1'b1;
                        r_gap     <= '0;
                    end
                end
                ST_GAP: begin
                    if (w_fall) begin
                        if (r_gap == C_GAP_LAST) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gap <= r_gap + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cs_n     = r_cs_n;
    assign sclk_out = r_sclk_out;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: divider model, mode-0 peripheral model and
// frame-level expectations derived from bit counts and sclk periods.

`timescale 1ns/1ps

module tb_spi_frame_master;

    localparam int FB  = 16;
    localparam int GAP = 2;
`ifdef MOSI_TX_EN
    localparam bit TX_EN = 1'b1;
`else
    localparam bit TX_EN = 1'b0;
`endif

    logic          clknexys;
    logic          rst;
    logic          SCLKclk = 1'b0;
    logic          start;
    logic [FB-1:0] tx_data;
    logic          miso;
    logic          cs_n;
    logic          sclk_out;
    logic          mosi;
    logic          busy;
    logic          done;
    logic [FB-1:0] rx_data;

    int total = 0;
    int bad   = 0;

    spi_frame_master #(
        .FRAME_BITS(FB),
        .IDLE_GAP  (GAP)
    ) dut (
        .clknexys(clknexys),
        .rst     (rst),
        .SCLKclk (SCLKclk),
        .start   (start),
        .tx_data (tx_data),
        .miso    (miso),
        .cs_n    (cs_n),
        .sclk_out(sclk_out),
        .mosi    (mosi),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data)
    );

    initial clknexys = 1'b0;
    always #5 clknexys = ~clknexys;

    // Divider: SCLKclk toggles every 'half' clknexys cycles while running.
    int half = 1;
    bit sclk_run = 1'b1;
    int dcnt = 0;
    always @(posedge clknexys) begin
        if (sclk_run) begin
            if (dcnt >= half - 1) begin
                dcnt    <= 0;
                SCLKclk <= ~SCLKclk;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    // Peripheral: shifts pword out on sclk_out falls, captures mosi on rises.
    logic [FB-1:0] pword;
    logic [FB-1:0] pcap;
    logic          pbit;
    bit            lb;
    int pidx, n_rise, n_done, n_cs, n_stray, n_mosi1;
    int cyc;
    int t_cs_fall, t_cs_rise, t_first_rise, t_last_rise, t_busy_fall;

    always_comb pbit = (pidx < FB) ? pword[FB-1-pidx] : 1'b0;
    assign miso = lb ? mosi : pbit;

    always @(negedge cs_n) begin
        pidx = 0;
        n_cs++;
        t_cs_fall = cyc;
    end
    always @(posedge cs_n) t_cs_rise = cyc;
    always @(negedge busy) t_busy_fall = cyc;
    always @(negedge sclk_out) if (!cs_n) pidx++;
    always @(posedge sclk_out) begin
        if (!cs_n) begin
            pcap = {pcap[FB-2:0], mosi};
            n_rise++;
            t_last_rise = cyc;
            if (n_rise == 1) t_first_rise = cyc;
        end
    end
    always @(negedge clknexys) begin
        cyc++;
        if (done) n_done++;
        if (sclk_out && cs_n) n_stray++;
        if (!TX_EN && mosi) n_mosi1++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_rise = 0;
        n_done = 0;
        n_cs = 0;
        n_stray = 0;
        n_mosi1 = 0;
        pcap = '0;
        pidx = 0;
    endtask

    task automatic pulse_start(input logic [FB-1:0] tx);
        @(negedge clknexys);
        tx_data = tx;
        start = 1'b1;
        @(negedge clknexys);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 4000) begin
            @(negedge clknexys);
            k++;
        end
        check({tag, "_tmo"}, {31'd0, busy}, 0);
    endtask

    task automatic wait_rises(input int n, input string tag);
        int k = 0;
        while (n_rise < n && k < 2000) begin
            @(negedge clknexys);
            k++;
        end
        check({tag, "_rise_tmo"}, n_rise, n);
    endtask

    task automatic set_div(input int h);
        half = h;
        repeat (4 * h + 4) @(negedge clknexys);
    endtask

    task automatic run_frame(input logic [FB-1:0] tx, input logic [FB-1:0] pw,
                             input bit l, input int h, input string tag);
        logic [FB-1:0] exp_mosi;
        logic [FB-1:0] exp_rx;
        lb = l;
        pword = pw;
        set_div(h);
        clear_mon();
        pulse_start(tx);
        check({tag, "_busy"}, {31'd0, busy}, 1);
        wait_idle(tag);
        exp_mosi = TX_EN ? tx : '0;
        exp_rx = l ? exp_mosi : pw;
        check({tag, "_rx"}, rx_data, exp_rx);
        check({tag, "_mosi"}, pcap, exp_mosi);
        check({tag, "_rises"}, n_rise, FB);
        check({tag, "_done"}, n_done, 1);
        check({tag, "_cs"}, n_cs, 1);
        check({tag, "_stray"}, n_stray, 0);
        check({tag, "_mosi0"}, n_mosi1, 0);
        check({tag, "_hold"}, t_cs_rise - t_last_rise, 3 * h);
        check({tag, "_gap"}, t_busy_fall - t_cs_rise, GAP * 2 * h);
        check({tag, "_setup"},
              {31'd0, (t_first_rise - t_cs_fall) >= h + 1}, 1);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        tx_data = '0;
        lb = 1'b0;
        pword = '0;
        cyc = 0;
        clear_mon();
        repeat (5) @(negedge clknexys);
        check("rst_cs_n", {31'd0, cs_n}, 1);
        check("rst_sclk", {31'd0, sclk_out}, 0);
        check("rst_mosi", {31'd0, mosi}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_rx", rx_data, 16'h0000);
        rst = 1'b1;
        repeat (3) @(negedge clknexys);

        run_frame(16'hA5C3, 16'h0000, 1'b1, 1, "loop");
        run_frame(16'h3C5A, 16'hFFFF, 1'b0, 2, "ones");

        // Second start mid-frame must be ignored.
        lb = 1'b0;
        pword = 16'h6E21;
        set_div(2);
        clear_mon();
        pulse_start(16'h0F0F);
        wait_rises(5, "ign");
        pulse_start(16'hFFFF);
        wait_idle("ign");
        repeat (20) @(negedge clknexys);
        check("ign_cs", n_cs, 1);
        check("ign_done", n_done, 1);
        check("ign_rx", rx_data, 16'h6E21);
        check("ign_busy", {31'd0, busy}, 0);

        // Asynchronous reset mid-frame.
        lb = 1'b1;
        set_div(3);
        clear_mon();
        pulse_start(16'hBEEF);
        wait_rises(7, "arst");
        #2;
        rst = 1'b0;
        #1;
        check("arst_cs_n", {31'd0, cs_n}, 1);
        check("arst_sclk", {31'd0, sclk_out}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        repeat (3) @(negedge clknexys);
        rst = 1'b1;
        repeat (20) @(negedge clknexys);
        check("arst_done", n_done, 0);
        check("arst_rx", rx_data, 16'h0000);
        run_frame(16'h1234, 16'h0000, 1'b1, 2, "post");

        // Stalled divider: frame opens but never advances.
        lb = 1'b0;
        pword = 16'hC0DE;
        set_div(2);
        while (SCLKclk) @(negedge clknexys);
        sclk_run = 1'b0;
        clear_mon();
        pulse_start(16'h5A5A);
        check("stall_busy", {31'd0, busy}, 1);
        check("stall_cs", {31'd0, cs_n}, 0);
        repeat (100) @(negedge clknexys);
        check("stall_rise", n_rise, 0);
        check("stall_done", n_done, 0);
        check("stall_hold", {31'd0, busy}, 1);
        sclk_run = 1'b1;
        wait_idle("stall");
        check("stall_rx", rx_data, 16'hC0DE);

        for (int i = 0; i < 8; i++) begin
            run_frame(FB'($urandom), FB'($urandom),
                      1'($urandom_range(0, 1)), $urandom_range(1, 4), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
